// File: rtl/echo_ram_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// echo_pkg
// Shared definitions for the echo-delay RAM sequencer: FSM state encoding,
// default bus widths and the constants used to form the delay value.
// ---------------------------------------------------------------------------
package echo_pkg;

    localparam int ADDR_W_DEF = 13;   // circular buffer depth 2^13
    localparam int DATA_W_DEF = 9;    // stored sample is y[9:1]

    // Target delay is {var_in, DELAY_LSB}; the forced LSB keeps it odd and >= 1.
    localparam logic [2:0] DELAY_LSB = 3'b001;
    localparam int         DELAY_MIN = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        ADV  = 3'd5
    } state_e;

endpackage

// File: rtl/echo_ram_sequencer_if.sv
// ---------------------------------------------------------------------------
// echo_ram_sequencer_if
// Bus between the sequencer (master) and the echo-delay RAM (slave).
//   ram_rdaddr / ram_rden : read port, q returns RAM_LAT cycles after rden
//   ram_wraddr / ram_wren / ram_wdata : write port
//   ram_q : read data back from the RAM
// Enables are single-cycle qualifiers: an address is only meaningful in the
// cycle its enable is high, and rden/wren are never high together.
// ---------------------------------------------------------------------------
interface echo_ram_sequencer_if
    import echo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [ADDR_W-1:0] ram_wraddr;
    logic              ram_rden;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output ram_rdaddr, ram_wraddr, ram_rden, ram_wren, ram_wdata,
        input  ram_q
    );

    modport slave (
        input  ram_rdaddr, ram_wraddr, ram_rden, ram_wren, ram_wdata,
        output ram_q
    );
endinterface

// File: rtl/echo_ram_sequencer_strobe_sync.sv
// ---------------------------------------------------------------------------
// strobe_sync
// Brings the asynchronous 10 kHz data_valid strobe into the sysclk domain
// (2-FF synchroniser) and turns its rising edge into a registered one-cycle
// pulse, three sysclk edges after the strobe rises.
//   clk, rst : sysclk, asynchronous active-high reset (all flops to 0)
//   d_i      : asynchronous strobe
//   pulse_o  : one-cycle start pulse
// ---------------------------------------------------------------------------
module strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= d_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/echo_ram_sequencer.sv
// ---------------------------------------------------------------------------
// echo_ram_sequencer
// Once per sample strobe: read the delayed sample at rd_ptr, latch it for the
// echo subtractor, write the current sample y[9:1] at rd_ptr+delay_cur, then
// advance rd_ptr and move delay_cur toward the target selected by var_in.
//
// Ports:
//   sysclk, reset   : clock, asynchronous active-high reset
//   data_valid      : asynchronous sample strobe
//   var_in          : delay select, target delay = {var_in, 3'b001}
//   y_in            : current echo-loop output (two's complement)
//   ram             : RAM bus (master side, see echo_ram_sequencer_if)
//   echo_q          : latched delayed sample
//   echo_valid      : one-cycle pulse in the capture cycle (echo_q takes the
//                     new value on the closing edge of that cycle)
//   busy            : sequence in progress (state != IDLE)
//   overrun         : sticky, a strobe arrived while busy (that strobe dropped)
//   dbg_state_o, dbg_rd_ptr_o, dbg_delay_cur_o : internal state for observation
//
// Build option: ECHO_DELAY_GLIDE_EN - when defined, delay_cur slews toward the
// target by at most GLIDE_STEP per sample; otherwise it jumps in one sample.
//
// Timing with RAM_LAT=1, cycle s = start pulse high:
//   s+1 RD (rden), s+2 CAP (echo_valid), s+3 WR (wren), s+4 ADV, s+5 IDLE.
// ---------------------------------------------------------------------------
module echo_ram_sequencer
    import echo_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RAM_LAT    = 1,
    parameter int GLIDE_STEP = 8
)(
    input  logic               sysclk,
    input  logic               reset,
    input  logic               data_valid,
    input  logic [9:0]         var_in,
    input  logic [9:0]         y_in,
    echo_ram_sequencer_if.master ram,
    output logic [DATA_W-1:0]  echo_q,
    output logic               echo_valid,
    output logic               busy,
    output logic               overrun,
    output state_e             dbg_state_o,
    output logic [ADDR_W-1:0]  dbg_rd_ptr_o,
    output logic [ADDR_W-1:0]  dbg_delay_cur_o
);
    localparam logic [ADDR_W-1:0] DELAY_MIN_W  = ADDR_W'(DELAY_MIN);
    localparam logic [ADDR_W-1:0] GLIDE_STEP_W = ADDR_W'(GLIDE_STEP);
    // Last count of the WAIT state; WAIT is skipped entirely when RAM_LAT=1.
    localparam logic [7:0]        WAIT_LAST    = 8'((RAM_LAT > 1) ? RAM_LAT - 2 : 0);

    logic               start;
    state_e             state_q;
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [ADDR_W-1:0]  delay_cur_q;
    logic [ADDR_W-1:0]  delay_tgt_q;
    logic [ADDR_W-1:0]  delay_nxt_d;
    logic [7:0]         wait_cnt_q;
    logic               rden_q;
    logic               wren_q;
    logic               echo_valid_q;
    logic               busy_q;
    logic               overrun_q;
    logic [DATA_W-1:0]  echo_q_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               unused_y_lsb;

    assign unused_y_lsb = y_in[0];

    strobe_sync u_strobe_sync (
        .clk     (sysclk),
        .rst     (reset),
        .d_i     (data_valid),
        .pulse_o (start)
    );

    // Delay value that ADV will load into delay_cur.
    always_comb begin
        delay_nxt_d = delay_tgt_q;
`ifdef ECHO_DELAY_GLIDE_EN
        if (delay_tgt_q > delay_cur_q) begin
            if ((delay_tgt_q - delay_cur_q) > GLIDE_STEP_W)
                delay_nxt_d = delay_cur_q + GLIDE_STEP_W;
        end else begin
            if ((delay_cur_q - delay_tgt_q) > GLIDE_STEP_W)
                delay_nxt_d = delay_cur_q - GLIDE_STEP_W;
        end
`endif
    end

    // Enables and echo_valid are registered on the transition into the state
    // they belong to, so each is high for exactly the cycle spent there.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            delay_cur_q  <= DELAY_MIN_W;
            delay_tgt_q  <= DELAY_MIN_W;
            wait_cnt_q   <= '0;
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
            echo_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            echo_q_q     <= '0;
            wdata_q      <= '0;
        end else begin
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
            echo_valid_q <= 1'b0;
            if (start && (state_q != IDLE))
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RD;
                        rden_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        delay_tgt_q <= ADDR_W'({var_in, DELAY_LSB});
                    end
                end
                RD: begin
                    if (RAM_LAT > 1) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end else begin
                        state_q      <= CAP;
                        echo_valid_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q      <= CAP;
                        echo_valid_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                CAP: begin
                    echo_q_q <= ram.ram_q;
                    wdata_q  <= y_in[9:1];
                    state_q  <= WR;
                    wren_q   <= 1'b1;
                end
                WR: begin
                    state_q <= ADV;
                end
                ADV: begin
                    rd_ptr_q    <= rd_ptr_q + 1'b1;   // wraps at 2^ADDR_W
                    delay_cur_q <= delay_nxt_d;
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Addresses decode from registered pointers only, so they are stable
    // around the enable cycles; the modulo comes from the ADDR_W-bit add.
    assign ram.ram_rdaddr = rd_ptr_q;
    assign ram.ram_wraddr = rd_ptr_q + delay_cur_q;
    assign ram.ram_rden   = rden_q;
    assign ram.ram_wren   = wren_q;
    assign ram.ram_wdata  = wdata_q;

    assign echo_q          = echo_q_q;
    assign echo_valid      = echo_valid_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;
    assign dbg_state_o     = state_q;
    assign dbg_rd_ptr_o    = rd_ptr_q;
    assign dbg_delay_cur_o = delay_cur_q;
endmodule

// File: tb/tb_echo_ram_sequencer.sv
// ---------------------------------------------------------------------------
// tb_echo_ram_sequencer
// Drives sample strobes into echo_ram_sequencer with a behavioural RAM
// (latency 1). Each issued sample pushes its expected read address, echo
// value and write address/data; a monitor forked in the main process pops
// and compares whenever the DUT presents rden, wren or echo_valid.
// ---------------------------------------------------------------------------
module tb_echo_ram_sequencer;
    import echo_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          dv     = 1'b0;
    logic [9:0]    var_in = '0;
    logic [9:0]    y_in   = '0;
    logic [DW-1:0] echo_q;
    logic          echo_valid;
    logic          busy;
    logic          overrun;
    state_e        dbg_state;
    logic [AW-1:0] dbg_rd_ptr;
    logic [AW-1:0] dbg_delay_cur;

    echo_ram_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

    echo_ram_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1), .GLIDE_STEP(8)) dut (
        .sysclk          (clk),
        .reset           (rst),
        .data_valid      (dv),
        .var_in          (var_in),
        .y_in            (y_in),
        .ram             (ram_if),
        .echo_q          (echo_q),
        .echo_valid      (echo_valid),
        .busy            (busy),
        .overrun         (overrun),
        .dbg_state_o     (dbg_state),
        .dbg_rd_ptr_o    (dbg_rd_ptr),
        .dbg_delay_cur_o (dbg_delay_cur)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural RAM, read latency 1 ----------------
    logic [DW-1:0] ram_mem [0:DEPTH-1] = '{default: '0};
    always @(posedge clk) begin
        if (ram_if.ram_rden) ram_if.ram_q <= ram_mem[ram_if.ram_rdaddr];
        if (ram_if.ram_wren) ram_mem[ram_if.ram_wraddr] <= ram_if.ram_wdata;
    end

    // ---------------- scoreboard state ----------------
    logic [AW-1:0]    exp_rd_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [DW-1:0]    exp_echo_q[$];

    logic [DW-1:0] m_mem [0:DEPTH-1];
    int m_ptr;
    int m_delay;
    int m_tgt;

    int n_checks = 0;
    int n_errors = 0;
    int rise_cyc, rden_cyc, echo_cyc, wren_cyc;
    logic [AW-1:0] last_rd, last_wr;
    logic [DW-1:0] last_wdata;
    logic echo_pend;
    bit   found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    // Expected behaviour of one sample from the bench's own model.
    task automatic push_expect(input logic [9:0] v, input logic [9:0] y);
        int waddr;
        m_tgt = {19'd0, v, 3'b001};
        exp_rd_q.push_back(AW'(m_ptr));
        exp_echo_q.push_back(m_mem[m_ptr]);
        waddr = (m_ptr + m_delay) % DEPTH;
        exp_wr_q.push_back({AW'(waddr), y[9:1]});
        m_mem[waddr] = y[9:1];
        m_ptr = (m_ptr + 1) % DEPTH;
`ifdef ECHO_DELAY_GLIDE_EN
        if (m_tgt > m_delay) m_delay = (m_tgt - m_delay > 8) ? m_delay + 8 : m_tgt;
        else                 m_delay = (m_delay - m_tgt > 8) ? m_delay - 8 : m_tgt;
`else
        m_delay = m_tgt;
`endif
    endtask

    task automatic issue_sample(input logic [9:0] v, input logic [9:0] y, input int gap);
        push_expect(v, y);
        @(negedge clk);
        var_in   = v;
        y_in     = y;
        dv       = 1'b1;
        rise_cyc = cyc;
        repeat (2) @(negedge clk);
        dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ptr = 0; m_delay = 1; m_tgt = 1;
        echo_pend = 1'b0;
        rden_cyc = 0; echo_cyc = 0; wren_cyc = 0; rise_cyc = 0;
        last_rd = '0; last_wr = '0; last_wdata = '0;

        fork
            // ---------------- monitor ----------------
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (ram_if.ram_rden && ram_if.ram_wren) fail("rden_wren_overlap");
                    if (echo_pend) begin
                        echo_pend = 1'b0;
                        if (exp_echo_q.size() == 0) fail("echo_q");
                        else check("echo_q", 32'(echo_q), 32'(exp_echo_q.pop_front()));
                    end
                    if (echo_valid) begin
                        echo_pend = 1'b1;
                        echo_cyc  = cyc;
                    end
                    if (ram_if.ram_rden) begin
                        rden_cyc = cyc;
                        last_rd  = ram_if.ram_rdaddr;
                        check("busy_in_rd", 32'(busy), 32'd1);
                        if (exp_rd_q.size() == 0) fail("rdaddr");
                        else check("rdaddr", 32'(ram_if.ram_rdaddr), 32'(exp_rd_q.pop_front()));
                    end
                    if (ram_if.ram_wren) begin
                        logic [AW+DW-1:0] e;
                        wren_cyc   = cyc;
                        last_wr    = ram_if.ram_wraddr;
                        last_wdata = ram_if.ram_wdata;
                        if (exp_wr_q.size() == 0) fail("wraddr");
                        else begin
                            e = exp_wr_q.pop_front();
                            check("wraddr", 32'(ram_if.ram_wraddr), 32'(e[AW+DW-1:DW]));
                            check("wdata", 32'(ram_if.ram_wdata), 32'(e[DW-1:0]));
                        end
                    end
                end
            end
        join_none

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_rden", 32'(ram_if.ram_rden), 32'd0);
        check("rst_wren", 32'(ram_if.ram_wren), 32'd0);
        check("rst_wraddr", 32'(ram_if.ram_wraddr), 32'd1);
        check("rst_rdaddr", 32'(ram_if.ram_rdaddr), 32'd0);
        check("rst_echo_q", 32'(echo_q), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_rden", 32'(ram_if.ram_rden), 32'd0);

        // ---------------- single sample, var_in=0 ----------------
        issue_sample(10'd0, 10'h2A6, 6);
        check("t_rden_lat", 32'(rden_cyc - rise_cyc), 32'd4);
        check("t_echo_lat", 32'(echo_cyc - rise_cyc), 32'd5);
        check("t_wren_lat", 32'(wren_cyc - rise_cyc), 32'd6);
        check("single_rd", 32'(last_rd), 32'd0);
        check("single_wr", 32'(last_wr), 32'd1);
        check("single_wdata", 32'(last_wdata), 32'h153);
        check("single_ptr", 32'(dbg_rd_ptr), 32'd1);
        check("single_busy_idle", 32'(busy), 32'd0);

        // ---------------- echo round trip ----------------
        issue_sample(10'd0, 10'h100, 6);   // writes 0x080 at address 2
        issue_sample(10'd0, 10'h000, 6);   // reads address 2
        check("roundtrip_echo", 32'(echo_q), 32'h080);

        // ---------------- overrun ----------------
        check("ovr_before", 32'(overrun), 32'd0);
        push_expect(10'd0, 10'h0F0);
        @(negedge clk); var_in = 10'd0; y_in = 10'h0F0; dv = 1'b1;
        repeat (2) @(negedge clk); dv = 1'b0;
        @(negedge clk); dv = 1'b1;
        repeat (2) @(negedge clk); dv = 1'b0;
        repeat (10) @(negedge clk);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_ptr", 32'(dbg_rd_ptr), 32'd4);

        // ---------------- delay change toward 81 ----------------
        for (int i = 0; i < 11; i++) begin
            issue_sample(10'd10, 10'(i * 29), 6);
            check("glide_delay", 32'(dbg_delay_cur), 32'(m_delay));
        end
        check("glide_final", 32'(dbg_delay_cur), 32'd81);

        // ---------------- wrap-around, delay 8185 ----------------
        while (m_ptr != 8190) issue_sample(10'h3FF, 10'(m_ptr * 37), 3);
        repeat (4) @(negedge clk);
        check("wrap_ptr", 32'(dbg_rd_ptr), 32'd8190);
        issue_sample(10'h3FF, 10'h155, 6);
        check("wrap_rd0", 32'(last_rd), 32'd8190);
        check("wrap_wr0", 32'(last_wr), 32'd8183);
        issue_sample(10'h3FF, 10'h0AA, 6);
        check("wrap_rd1", 32'(last_rd), 32'd8191);
        issue_sample(10'h3FF, 10'h033, 6);
        check("wrap_rd2", 32'(last_rd), 32'd0);
        check("wrap_ptr_after", 32'(dbg_rd_ptr), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // ---------------- reset during WR ----------------
        push_expect(10'd0, 10'h1FE);
        @(negedge clk); var_in = 10'd0; y_in = 10'h1FE; dv = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (i == 1) dv = 1'b0;
            if (ram_if.ram_wren) found = 1'b1;
        end
        check("mid_wr_reached", 32'(found), 32'd1);
        dv  = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_wren_drop", 32'(ram_if.ram_wren), 32'd0);
        check("mid_state", 32'(dbg_state), 32'(IDLE));
        check("mid_ptr", 32'(dbg_rd_ptr), 32'd0);
        check("mid_echo_q", 32'(echo_q), 32'd0);
        check("mid_overrun", 32'(overrun), 32'd0);
        exp_wr_q.delete();
        exp_echo_q.delete();
        echo_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_mid_en", 32'({ram_if.ram_rden, ram_if.ram_wren}), 32'd0);
        end
        check("post_mid_wraddr", 32'(ram_if.ram_wraddr), 32'd1);

        // ---------------- final ----------------
        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        check("echo_queue_empty", 32'(exp_echo_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
